lock_fsm_gen: RTL and testbench
===============================

Name: lock_fsm_gen

Overview:
Parametrised successor to the four-button digital lock FSM.
- Code length, code digits, disarm sequence, allowed wrong attempts and alarm flash rate are all parameters.
- Adds an in-block button synchroniser and edge detector, an attempt counter, and Moore status outputs.
- Sits between the raw NWSE push-buttons and the board LEDs and RGB LED.

Parameters:
- CODE_LEN, 4: number of digits in the unlock code; must be >= 1.
- CODE, 8'h76: unlock code, 2 bits per digit, digit 0 in bits [1:0]. Digit encoding: N=0, W=1, S=2, E=3. The default is S, W, E, W.
- DISARM_LEN, 2: number of digits in the alarm-disarm sequence; must be >= 1.
- DISARM_CODE, 4'hD: disarm sequence, same packing as CODE. The default is W, E.
- MAX_TRIES, 1: number of consecutive wrong full-length entries that raise the alarm; must be >= 1.
- FLASH_DIV, 25_000_000: number of clk cycles per red toggle in ALARM; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nwse  in  4  raw button levels, {N,W,S,E}, asynchronous to clk.
- led  out  4  progress display.
- rgb  out  3  {R,G,B} status colour.
- unlocked  out  1  high in UNLOCKED.
- alarm  out  1  high in ALARM.

Behaviour:
Reset:
- rst_n low clears all state immediately, without waiting for clk.
- Reset values: state=LOCKED, idx=0, err=0, tries=0, didx=0, flash counter=0, flash_on=1, sync/edge flops=0.
- Output values in reset: led=0, rgb=3'b001, unlocked=0, alarm=0.
- Reset may assert mid-entry or mid-alarm with the same result.

Press detection:
- nwse passes through a 2-flop synchroniser, giving s2, then one delay flop, giving s2_d.
- press is true when s2 != 0, s2_d == 0 and s2 is one-hot. digit = index of the set bit.
- A multi-bit s2 produces no press.
- Holding a button produces one press; the next press requires all buttons released.
- Pressing a second button while one is held produces no press.
- Latency: a level first sampled at edge k updates the FSM state at edge k+2.

LOCKED:
- Each press compares digit with CODE[2*idx +: 2]. A mismatch sets err. idx increments.
- On the press that completes the code (idx == CODE_LEN-1):
  - err clear and the final digit matches: go to UNLOCKED, tries=0.
  - otherwise: tries+1. If tries+1 == MAX_TRIES, go to ALARM; else stay in LOCKED.
  - In every case idx=0 and err=0.
- N is a valid code digit in LOCKED.

UNLOCKED:
- A press with digit N goes to LOCKED, idx=0.
- All other presses are ignored.

ALARM:
- A press matching DISARM_CODE[didx] increments didx.
- Completing the sequence goes to LOCKED with tries=0, didx=0.
- Any mismatch sets didx = (digit == DISARM_CODE[0]) ? 1 : 0.
- Entering ALARM clears the flash counter and sets flash_on=1.
- The flash counter counts 0..FLASH_DIV-1. flash_on toggles on wrap.
- The flash counter is held at 0 outside ALARM.

Outputs (Moore decode of registered state):
- led:
  - LOCKED: thermometer of idx, bit i = (i < idx), saturating at 4'hF.
  - UNLOCKED: 4'hF.
  - ALARM: thermometer of didx.
- rgb: LOCKED 001; UNLOCKED 010; ALARM {flash_on,0,0}.
- unlocked and alarm decode directly from state.

Widths:
- idx: $clog2(CODE_LEN+1).
- didx: $clog2(DISARM_LEN+1).
- tries: $clog2(MAX_TRIES+1).
- Flash counter: $clog2(FLASH_DIV+1).
- No counter can overflow; all advances are bounded by the comparisons above.

Decomposition:
- Package lock_pkg:
  - state_e enum {LOCKED, UNLOCKED, ALARM}.
  - Digit constants DIR_N=0, DIR_W=1, DIR_S=2, DIR_E=3.
  - Function onehot_to_digit.
  - RGB colour constants.
- Sub-module btn_sync_edge (parameter W=4): synchroniser, delay flop, press strobe and digit output.
- The FSM, attempt counter and flash counter live in lock_fsm_gen.

Test Plan:
All scenarios use FLASH_DIV=2 and default codes unless stated. Each press is held for 2 cycles, followed by at least 4 idle cycles.
1. Assert rst_n low for 3 cycles, then release -> led=0, rgb=001, unlocked=0, alarm=0. Then press S,W,E,W -> led steps 1,3,7 after each of the first three presses; after the 4th press rgb=010, unlocked=1, led=F. Then press N -> rgb=001, led=0.
2. Press S,N,E,W -> after the 4th press alarm=1 and rgb alternates 100/000 every 2 cycles, starting at 100. Then press E -> stays in ALARM, led=0.
3. In ALARM press W -> led=1. Press S -> didx=0, led=0. Press W, E -> state LOCKED, rgb=001, tries=0. Repeat with the sequence W, W, E -> W, W leaves didx=1, and E disarms.
4. With MAX_TRIES=3: two wrong 4-digit entries -> remain LOCKED with alarm=0; third wrong entry -> alarm=1. Then disarm and enter the correct code -> unlocked=1.
5. Hold S for 20 cycles -> exactly one press (led=1). Press W while S is still held -> ignored. Press N+S simultaneously -> ignored, led unchanged.
6. Press S,W, then pulse rst_n low asynchronously between clk edges -> outputs reach reset values before the next edge. After release, press S,W,E,W -> unlocked=1.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types, digit encodings and colour constants for the parametrised
// four-button lock.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    ALARM    = 2'd2
  } state_e;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_E = 2'd3;

  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_OFF   = 3'b000;

  localparam logic [3:0] LED_ALL = 4'hF;

  // Button vector is {N,W,S,E}, so the MSB is digit 0.
  function automatic logic [1:0] onehot_to_digit(input logic [3:0] oh);
    logic [1:0] dig;
    case (oh)
      4'b1000: dig = DIR_N;
      4'b0100: dig = DIR_W;
      4'b0010: dig = DIR_S;
      4'b0001: dig = DIR_E;
      default: dig = DIR_N;
    endcase
    return dig;
  endfunction

  function automatic logic [3:0] thermo4(input int unsigned n);
    logic [3:0] t;
    t = 4'h0;
    for (int unsigned i = 0; i < 4; i++) begin
      t[i] = (n > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw buttons plus a delay flop; emits a
// single-cycle press strobe for a clean one-hot press from all-released.
module btn_sync_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_i,
  output logic         press_o,
  output logic [1:0]   digit_o
);
  import lock_pkg::*;

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] s2_dly_q, s2_dly_d;
  logic         onehot_s;

  always_comb begin
    s1_d     = btn_i;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= {W{1'b0}};
      s2_q     <= {W{1'b0}};
      s2_dly_q <= {W{1'b0}};
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s2_dly_q <= s2_dly_d;
    end
  end

  // A second button joining a held one never qualifies: s2_dly is non-zero.
  always_comb begin
    onehot_s = (s2_q != {W{1'b0}}) &&
               ((s2_q & (s2_q - {{(W-1){1'b0}}, 1'b1})) == {W{1'b0}});
    press_o  = onehot_s && (s2_dly_q == {W{1'b0}});
    digit_o  = onehot_to_digit(s2_q);
  end

endmodule

// File: rtl/lock_fsm_gen.sv
// Parametrised digital lock: code entry, attempt counting, alarm with
// disarm sequence and flashing red, Moore status outputs.
module lock_fsm_gen #(
  parameter int                        CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0]     CODE        = 8'h76,
  parameter int                        DISARM_LEN  = 2,
  parameter logic [2*DISARM_LEN-1:0]   DISARM_CODE = 4'hD,
  parameter int                        MAX_TRIES   = 1,
  parameter int                        FLASH_DIV   = 32'd25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nwse,
  output logic [3:0] led,
  output logic [2:0] rgb,
  output logic       unlocked,
  output logic       alarm
);
  import lock_pkg::*;

  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int DIDX_W = $clog2(DISARM_LEN + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int FCNT_W = $clog2(FLASH_DIV + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [DIDX_W-1:0] DIDX_DONE = DIDX_W'(DISARM_LEN);
  localparam logic [TRY_W-1:0]  TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLASH_DIV - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [DIDX_W-1:0] didx_q, didx_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              flash_on_q, flash_on_d;
  logic [3:0]        led_q, led_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              unlocked_q, unlocked_d;
  logic              alarm_q, alarm_d;

  logic              press_s;
  logic [1:0]        digit_s;
  logic [1:0]        code_dig_s;
  logic [1:0]        dis_dig_s;

  btn_sync_edge #(.W(4)) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (nwse),
    .press_o (press_s),
    .digit_o (digit_s)
  );

  // Expected digit at the current entry position of each sequence.
  always_comb begin
    code_dig_s = DIR_N;
    dis_dig_s  = DIR_N;
    for (int i = 0; i < CODE_LEN; i++) begin
      code_dig_s = (idx_q == IDX_W'(i)) ? CODE[2*i +: 2] : code_dig_s;
    end
    for (int j = 0; j < DISARM_LEN; j++) begin
      dis_dig_s = (didx_q == DIDX_W'(j)) ? DISARM_CODE[2*j +: 2] : dis_dig_s;
    end
  end

  // Next state, counters, and output decode of the next state so the
  // registered outputs track the registered state without lag.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    tries_d    = tries_q;
    didx_d     = didx_q;
    fcnt_d     = {FCNT_W{1'b0}};
    flash_on_d = 1'b1;
    led_d      = 4'h0;
    rgb_d      = RGB_BLUE;
    unlocked_d = 1'b0;
    alarm_d    = 1'b0;

    case (state_q)
      LOCKED: begin
        if (!press_s) begin
          state_d = LOCKED;
        end else if (idx_q == IDX_LAST) begin
          idx_d = {IDX_W{1'b0}};
          err_d = 1'b0;
          if (!err_q && (digit_s == code_dig_s)) begin
            state_d = UNLOCKED;
            tries_d = {TRY_W{1'b0}};
          end else begin
            tries_d = tries_q + TRY_W'(1);
            if ((tries_q + TRY_W'(1)) == TRY_LIMIT) begin
              state_d = ALARM;
              didx_d  = {DIDX_W{1'b0}};
            end else begin
              state_d = LOCKED;
            end
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
          err_d = err_q | (digit_s != code_dig_s);
        end
      end
      UNLOCKED: begin
        if (press_s && (digit_s == DIR_N)) begin
          state_d = LOCKED;
          idx_d   = {IDX_W{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = UNLOCKED;
        end
      end
      ALARM: begin
        if (!press_s) begin
          state_d = ALARM;
        end else if (digit_s == dis_dig_s) begin
          if ((didx_q + DIDX_W'(1)) == DIDX_DONE) begin
            state_d = LOCKED;
            tries_d = {TRY_W{1'b0}};
            didx_d  = {DIDX_W{1'b0}};
          end else begin
            didx_d  = didx_q + DIDX_W'(1);
          end
        end else begin
          // A wrong digit may itself be the start of a fresh attempt.
          didx_d = (digit_s == DISARM_CODE[1:0]) ? DIDX_W'(1) : {DIDX_W{1'b0}};
        end
      end
      default: begin
        state_d = LOCKED;
        idx_d   = {IDX_W{1'b0}};
        err_d   = 1'b0;
        tries_d = {TRY_W{1'b0}};
        didx_d  = {DIDX_W{1'b0}};
      end
    endcase

    if ((state_q == ALARM) && (state_d == ALARM)) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d     = {FCNT_W{1'b0}};
        flash_on_d = ~flash_on_q;
      end else begin
        fcnt_d     = fcnt_q + FCNT_W'(1);
        flash_on_d = flash_on_q;
      end
    end else begin
      fcnt_d     = {FCNT_W{1'b0}};
      flash_on_d = 1'b1;
    end

    case (state_d)
      LOCKED: begin
        led_d = thermo4(32'(idx_d));
        rgb_d = RGB_BLUE;
      end
      UNLOCKED: begin
        led_d = LED_ALL;
        rgb_d = RGB_GREEN;
      end
      ALARM: begin
        led_d = thermo4(32'(didx_d));
        rgb_d = flash_on_d ? RGB_RED : RGB_OFF;
      end
      default: begin
        led_d = 4'h0;
        rgb_d = RGB_BLUE;
      end
    endcase
    unlocked_d = (state_d == UNLOCKED);
    alarm_d    = (state_d == ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOCKED;
      idx_q      <= {IDX_W{1'b0}};
      err_q      <= 1'b0;
      tries_q    <= {TRY_W{1'b0}};
      didx_q     <= {DIDX_W{1'b0}};
      fcnt_q     <= {FCNT_W{1'b0}};
      flash_on_q <= 1'b1;
      led_q      <= 4'h0;
      rgb_q      <= RGB_BLUE;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      tries_q    <= tries_d;
      didx_q     <= didx_d;
      fcnt_q     <= fcnt_d;
      flash_on_q <= flash_on_d;
      led_q      <= led_d;
      rgb_q      <= rgb_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign led      = led_q;
  assign rgb      = rgb_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_lock_fsm_gen.sv
// Bench for lock_fsm_gen: two instances (1 and 3 allowed tries) checked each
// cycle against an abstract model, plus hand-computed directed expectations.
module tb_lock_fsm_gen;

  localparam int FD = 2;
  localparam logic [3:0] BN = 4'b1000;
  localparam logic [3:0] BW = 4'b0100;
  localparam logic [3:0] BS = 4'b0010;
  localparam logic [3:0] BE = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] nwse1, nwse3;
  logic [3:0] led1, led3;
  logic [2:0] rgb1, rgb3;
  logic       unl1, unl3, alm1, alm3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lock_fsm_gen #(.MAX_TRIES(1), .FLASH_DIV(FD)) dut1 (
    .clk(clk), .rst_n(rst_n), .nwse(nwse1),
    .led(led1), .rgb(rgb1), .unlocked(unl1), .alarm(alm1)
  );

  lock_fsm_gen #(.MAX_TRIES(3), .FLASH_DIV(FD)) dut3 (
    .clk(clk), .rst_n(rst_n), .nwse(nwse3),
    .led(led3), .rgb(rgb3), .unlocked(unl3), .alarm(alm3)
  );

  // mode: 0 locked, 1 open, 2 alarm; n = digits typed so far; ok = all matched;
  // acyc = cycles spent in alarm; h1..h3 = raw button samples, newest first.
  typedef struct packed {
    int mode; int n; int ok; int tries; int didx; int acyc;
    logic [3:0] h1; logic [3:0] h2; logic [3:0] h3;
  } mdl_t;

  mdl_t m1, m3;

  function automatic int code_digit(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int dis_digit(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int btn_digit(input logic [3:0] b);
    case (b)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0001: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r = '0;
    r.ok = 1;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic [3:0] cur, input int maxt);
    mdl_t r;
    int d;
    bit p;
    r = m;
    d = btn_digit(m.h2);
    p = (d >= 0) && (m.h3 == 4'b0000);
    if (m.mode == 2) r.acyc = m.acyc + 1;
    if (p) begin
      case (m.mode)
        0: begin
          r.ok = (m.ok != 0 && d == code_digit(m.n)) ? 1 : 0;
          if (m.n == 3) begin
            if (r.ok != 0) begin
              r.mode = 1; r.tries = 0;
            end else begin
              r.tries = m.tries + 1;
              if (r.tries == maxt) begin
                r.mode = 2; r.acyc = 0; r.didx = 0;
              end
            end
            r.n = 0; r.ok = 1;
          end else begin
            r.n = m.n + 1;
          end
        end
        1: if (d == 0) begin r.mode = 0; r.n = 0; r.ok = 1; end
        2: begin
          if (d == dis_digit(m.didx)) begin
            if (m.didx + 1 == 2) begin
              r.mode = 0; r.tries = 0; r.didx = 0; r.n = 0; r.ok = 1;
            end else begin
              r.didx = m.didx + 1;
            end
          end else begin
            r.didx = (d == dis_digit(0)) ? 1 : 0;
          end
        end
        default: ;
      endcase
    end
    r.h3 = m.h2; r.h2 = m.h1; r.h1 = cur;
    return r;
  endfunction

  function automatic logic [3:0] exp_led(input mdl_t m);
    int k;
    if (m.mode == 1) return 4'hF;
    k = (m.mode == 0) ? m.n : m.didx;
    return (k >= 4) ? 4'hF : 4'((1 << k) - 1);
  endfunction

  function automatic logic [2:0] exp_rgb(input mdl_t m);
    if (m.mode == 0) return 3'b001;
    if (m.mode == 1) return 3'b010;
    return (((m.acyc / FD) % 2) == 0) ? 3'b100 : 3'b000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= mreset();
      m3 <= mreset();
    end else begin
      m1 <= mstep(m1, nwse1, 1);
      m3 <= mstep(m3, nwse3, 3);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("d1.led", led1, exp_led(m1));
    chk("d1.rgb", {1'b0, rgb1}, {1'b0, exp_rgb(m1)});
    chk("d1.unlocked", {3'b000, unl1}, {3'b000, m1.mode == 1});
    chk("d1.alarm", {3'b000, alm1}, {3'b000, m1.mode == 2});
    chk("d3.led", led3, exp_led(m3));
    chk("d3.rgb", {1'b0, rgb3}, {1'b0, exp_rgb(m3)});
    chk("d3.unlocked", {3'b000, unl3}, {3'b000, m3.mode == 1});
    chk("d3.alarm", {3'b000, alm3}, {3'b000, m3.mode == 2});
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic drive(input int inst, input logic [3:0] b);
    if (inst == 1) nwse1 = b;
    else nwse3 = b;
  endtask

  task automatic press(input int inst, input logic [3:0] b);
    tick();
    drive(inst, b);
    repeat (2) tick();
    drive(inst, 4'b0000);
    repeat (6) tick();
  endtask

  task automatic enter4(input int inst, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(inst, a); press(inst, b); press(inst, c); press(inst, d);
  endtask

  initial begin
    nwse1 = 4'b0000;
    nwse3 = 4'b0000;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst.led", led1, 4'h0);
    chk("rst.rgb", {1'b0, rgb1}, 4'b0001);
    chk("rst.unlocked", {3'b000, unl1}, 4'b0000);
    chk("rst.alarm", {3'b000, alm1}, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("rel.led", led1, 4'h0);
    chk("rel.rgb", {1'b0, rgb1}, 4'b0001);

    // Scenario 1: correct code, then relock
    press(1, BS); chk("t1.led1", led1, 4'b0001);
    press(1, BW); chk("t1.led2", led1, 4'b0011);
    press(1, BE); chk("t1.led3", led1, 4'b0111);
    press(1, BW);
    chk("t1.rgb_open", {1'b0, rgb1}, 4'b0010);
    chk("t1.unlocked", {3'b000, unl1}, 4'b0001);
    chk("t1.led_open", led1, 4'hF);
    press(1, BN);
    chk("t1.rgb_relock", {1'b0, rgb1}, 4'b0001);
    chk("t1.led_relock", led1, 4'h0);

    // Scenario 2: wrong code raises alarm, red flashes every 2 cycles
    press(1, BS); press(1, BN); press(1, BE);
    chk("t2.led_err", led1, 4'b0111);
    press(1, BW);
    chk("t2.alarm", {3'b000, alm1}, 4'b0001);
    chk("t2.flash0", {1'b0, rgb1}, 4'b0100);
    tick(); chk("t2.flash1", {1'b0, rgb1}, 4'b0000);
    tick(); chk("t2.flash2", {1'b0, rgb1}, 4'b0000);
    tick(); chk("t2.flash3", {1'b0, rgb1}, 4'b0100);
    press(1, BE);
    chk("t2.still_alarm", {3'b000, alm1}, 4'b0001);
    chk("t2.led_e", led1, 4'h0);

    // Scenario 3: disarm with restart behaviour
    press(1, BW); chk("t3.led_w", led1, 4'b0001);
    press(1, BS); chk("t3.led_s", led1, 4'b0000);
    press(1, BW); press(1, BE);
    chk("t3.disarmed", {3'b000, alm1}, 4'b0000);
    chk("t3.rgb", {1'b0, rgb1}, 4'b0001);
    enter4(1, BS, BS, BS, BS);
    chk("t3.realarm", {3'b000, alm1}, 4'b0001);
    press(1, BW); chk("t3.ww1", led1, 4'b0001);
    press(1, BW); chk("t3.ww2", led1, 4'b0001);
    press(1, BE);
    chk("t3.disarm2", {3'b000, alm1}, 4'b0000);
    chk("t3.rgb2", {1'b0, rgb1}, 4'b0001);

    // Scenario 4: three allowed tries
    enter4(3, BS, BN, BE, BW); chk("t4.try1", {3'b000, alm3}, 4'b0000);
    enter4(3, BN, BW, BE, BW); chk("t4.try2", {3'b000, alm3}, 4'b0000);
    enter4(3, BS, BW, BE, BE); chk("t4.try3", {3'b000, alm3}, 4'b0001);
    press(3, BW); press(3, BE);
    chk("t4.disarm", {3'b000, alm3}, 4'b0000);
    enter4(3, BS, BS, BS, BS); chk("t4.after", {3'b000, alm3}, 4'b0000);
    enter4(3, BS, BW, BE, BW); chk("t4.open", {3'b000, unl3}, 4'b0001);

    // Scenario 5: long hold, second button while held, chord
    tick();
    drive(1, BS);
    repeat (20) tick();
    chk("t5.hold", led1, 4'b0001);
    drive(1, BS | BW);
    repeat (2) tick();
    drive(1, BS);
    repeat (2) tick();
    drive(1, 4'b0000);
    repeat (6) tick();
    chk("t5.second", led1, 4'b0001);
    drive(1, BN | BS);
    repeat (2) tick();
    drive(1, 4'b0000);
    repeat (6) tick();
    chk("t5.chord", led1, 4'b0001);

    // Scenario 6: asynchronous reset mid-entry
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    press(1, BS); press(1, BW);
    chk("t6.led_pre", led1, 4'b0011);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.async_led", led1, 4'h0);
    chk("t6.async_rgb", {1'b0, rgb1}, 4'b0001);
    chk("t6.async_unl", {3'b000, unl1}, 4'b0000);
    chk("t6.async_alm", {3'b000, alm1}, 4'b0000);
    chk("t6.async_d3unl", {3'b000, unl3}, 4'b0000);
    #1 rst_n = 1'b1;
    enter4(1, BS, BW, BE, BW);
    chk("t6.open", {3'b000, unl1}, 4'b0001);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
